fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 128 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Streams words from a registered-output FIFO onto a valid/ready interface.
// A 2-entry skid buffer absorbs the one-cycle FIFO read latency without bubbles.
module fifo_stream_reader #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [1:0]        r_buf_cnt;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              w_pop;
  logic              w_wr;
  logic [1:0]        w_occ;

  assign w_pop = m_valid & m_ready;
  assign w_wr  = r_inflight;

  // Occupancy next cycle before any new read; bounded by 2 since
  // buf_cnt + inflight never exceeds 2 and pop implies buf_cnt >= 1.
  assign w_occ = r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

  assign fifo_rd_en = (r_state == RUN) && !fifo_empty && (w_occ <= 2'd1);
  assign m_valid    = (r_buf_cnt != 2'd0);
  assign m_data     = r_buf0;
  assign busy       = (r_state != IDLE);
  assign word_cnt   = r_word_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (en) w_state_nxt = RUN;
      end
      RUN: begin
        if (!en) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (en) begin
          w_state_nxt = RUN;
        end else if ((r_buf_cnt == 2'd0) && !r_inflight) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  // Head is always r_buf0; a pop shifts r_buf1 forward, a write lands at the tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_buf_cnt <= '0;
    end else begin
      unique case ({w_wr, w_pop})
        2'b10: begin
          if (r_buf_cnt == 2'd0) begin
            r_buf0 <= fifo_data;
          end else begin
            r_buf1 <= fifo_data;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= fifo_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a FIFO model feeds the DUT and a
// scoreboard queue holds every pushed word until it appears on the output.
module tb_fifo_stream_reader;

  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] word_cnt;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_pushed;
  int            n_popped;
  int            ref_cnt;
  int            n_cmp;
  int            n_err;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  int            t_rd, t_v, last_v, nv, nrd, last_pop, t_idle, n_wrap;

  assign fifo_empty = (n_pushed == n_popped);

  fifo_stream_reader #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    n_pushed++;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    reset      = 1'b0;
    en         = 1'b0;
    m_ready    = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;

    fork
      // FIFO model: registered read data, one word per accepted read
      forever begin
        @(posedge clk);
        if (fifo_rd_en && !fifo_empty) begin
          fifo_data <= fifo_q.pop_front();
          n_popped  <= n_popped + 1;
        end
      end
      // Output monitor / scoreboard
      forever begin
        @(negedge clk);
        if (!reset) begin
          prev_stall = 1'b0;
        end else begin
          chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
          chk("rd_while_idle", fifo_rd_en & ~busy, 0);
          if (prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
          end
          if (m_valid && m_ready) begin
            chk("pop_has_expect", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("data_order", m_data, exp_q.pop_front());
            chk("word_cnt", word_cnt, ref_cnt % (1 << CW));
            ref_cnt++;
          end
          prev_stall = m_valid & ~m_ready;
          prev_data  = m_data;
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_word_cnt", word_cnt, 0);
    tick();
    reset = 1'b1;

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    tick();
    chk("idle_no_rd", fifo_rd_en, 0);
    en      = 1'b1;
    m_ready = 1'b1;
    t_rd = -1; t_v = -1; last_v = -1; nv = 0; nrd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        nrd++;
        if (t_rd < 0) t_rd = c;
      end
      if (m_valid) begin
        nv++;
        last_v = c;
        if (t_v < 0) t_v = c;
      end
    end
    tick();
    chk("stream_latency", t_v - t_rd, 2);
    chk("stream_words", nv, 8);
    chk("stream_contig", last_v - t_v, 7);
    chk("stream_reads", nrd, 8);
    chk("stream_word_cnt", word_cnt, 8);
    chk("stream_rd_empty", fifo_rd_en, 0);

    // Backpressure: 3,5,7 with m_ready low
    m_ready = 1'b0;
    push_word(DW'(3));
    push_word(DW'(5));
    push_word(DW'(7));
    nrd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
    end
    chk("bp_reads", nrd, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 3);
    tick();
    m_ready = 1'b1;
    wait_drained("bp_drained", 20);

    // Drain: en drops the cycle after a read is issued
    for (int i = 6; i <= 15; i++) push_word(DW'(i));
    @(negedge clk);
    chk("drain_rd_issued", fifo_rd_en, 1);
    tick();
    en = 1'b0;
    nrd = 0; last_pop = -1; t_idle = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 1 && fifo_rd_en) nrd++;
      if (m_valid && m_ready) last_pop = c;
      if (!busy && t_idle < 0) t_idle = c;
    end
    tick();
    chk("drain_no_rd", nrd, 0);
    chk("drain_busy_fall", t_idle - last_pop, 2);
    chk("drain_delivered", exp_q.size(), fifo_q.size());
    chk("drain_fifo_left", fifo_q.size(), 8);
    chk("drain_valid_low", m_valid, 0);
    en = 1'b1;
    wait_drained("drain_resume", 40);

    // Empty FIFO with en high
    @(negedge clk);
    chk("empty_rd_en", fifo_rd_en, 0);
    chk("empty_valid", m_valid, 0);
    chk("empty_busy", busy, 1);

    // Counter wrap at 256 pops
    tick();
    n_wrap = 256 - ref_cnt;
    for (int i = 0; i < n_wrap; i++) push_word(DW'(i));
    wait_drained("wrap_drained", 400);
    chk("wrap_total", ref_cnt, 256);
    chk("wrap_word_cnt", word_cnt, 0);

    // Mid-run reset with a full buffer
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    repeat (5) tick();
    chk("pre_rst_valid", m_valid, 1);
    reset = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    n_pushed = n_popped;
    ref_cnt  = 0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    repeat (2) tick();
    reset   = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_valid", m_valid, 0);
    end
    tick();
    push_word(DW'(9));
    wait_drained("post_rst_word", 20);
    chk("post_rst_word_cnt", word_cnt, 1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
